// File: rtl/port_display_scan_if.sv
// ============================================================================
// Module   : port_display_scan_if
// Brief    : Port-value inputs and 7-segment drive outputs of the scan block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface port_display_scan_if;
  logic [7:0] value_hi;
  logic [7:0] value_lo;
  logic       blank_lz;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  // Port-register side: supplies the values, observes the display drive.
  modport master (
    output value_hi, value_lo, blank_lz,
    input  anode, seg, dp
  );

  // Display scanner side.
  modport slave (
    input  value_hi, value_lo, blank_lz,
    output anode, seg, dp
  );
endinterface

`default_nettype wire

// File: rtl/port_display_scan.sv
// ============================================================================
// Module   : port_display_scan
// Brief    : Time-multiplexed 4-digit hex display of ports E1:E0, tear-free.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter bit DP_SEP      = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  port_display_scan_if.slave bus
);

  localparam int                 c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(REFRESH_DIV - 1);

  logic [c_CNT_W-1:0] r_div_cnt;
  logic [1:0]         r_idx;
  logic [7:0]         r_shadow_hi;
  logic [7:0]         r_shadow_lo;
  logic [3:0]         r_anode;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic               w_tick;
  logic               w_snap;
  logic [1:0]         w_idx_nxt;
  logic [7:0]         w_hi;
  logic [7:0]         w_lo;
  logic [3:0]         w_nib;
  logic               w_blank;
  logic [3:0]         w_anode;
  logic [6:0]         w_seg;
  logic               w_dp;

  assign w_tick    = (r_div_cnt == c_LAST);
  assign w_idx_nxt = r_idx + 2'd1;
  assign w_snap    = w_tick && (w_idx_nxt == 2'd0);

  // On the snapshot edge digit 0 shows the live values being captured.
  assign w_hi = w_snap ? bus.value_hi : r_shadow_hi;
  assign w_lo = w_snap ? bus.value_lo : r_shadow_lo;

  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (w_idx_nxt)
      2'd0: w_nib = w_lo[3:0];
      2'd1: begin
        w_nib   = w_lo[7:4];
        w_blank = bus.blank_lz && (w_hi == 8'h00) && (w_lo[7:4] == 4'h0);
      end
      2'd2: begin
        w_nib   = w_hi[3:0];
        w_blank = bus.blank_lz && (w_hi == 8'h00);
      end
      default: begin
        w_nib   = w_hi[7:4];
        w_blank = bus.blank_lz && (w_hi[7:4] == 4'h0);
      end
    endcase
  end

  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      default: w_seg = 7'b0001110;
    endcase
    w_anode = ~(4'b0001 << w_idx_nxt);
    w_dp    = ~(DP_SEP && (w_idx_nxt == 2'd2));
    if (w_blank) begin
      w_anode = 4'b1111;
      w_seg   = 7'b1111111;
      w_dp    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt   <= '0;
      r_idx       <= 2'd3;
      r_shadow_hi <= 8'h00;
      r_shadow_lo <= 8'h00;
      r_anode     <= 4'b1111;
      r_seg       <= 7'b1111111;
      r_dp        <= 1'b1;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_idx     <= w_idx_nxt;
      r_anode   <= w_anode;
      r_seg     <= w_seg;
      r_dp      <= w_dp;
      if (w_snap) begin
        r_shadow_hi <= bus.value_hi;
        r_shadow_lo <= bus.value_lo;
      end
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign bus.anode = r_anode;
  assign bus.seg   = r_seg;
  assign bus.dp    = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_port_display_scan.sv
// ============================================================================
// Module   : tb_port_display_scan
// Brief    : Randomized bench for port_display_scan with a slot-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_port_display_scan;

  localparam int DIV  = 4;
  localparam int DIV2 = 7;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  port_display_scan_if u_if ();
  port_display_scan_if u_if2 ();

  assign u_if2.value_hi = u_if.value_hi;
  assign u_if2.value_lo = u_if.value_lo;
  assign u_if2.blank_lz = u_if.blank_lz;

  port_display_scan #(.REFRESH_DIV(DIV), .DP_SEP(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  port_display_scan #(.REFRESH_DIV(DIV2), .DP_SEP(1'b0)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if2.slave)
  );

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {anode, seg, dp} for digit k of a 16-bit value.
  function automatic logic [11:0] disp(input int k, input logic [15:0] v, input logic blz, input bit dpsep);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [3:0]  an;
    upper = v >> (4 * k);
    nib   = upper[3:0];
    if (blz && k != 0 && upper == 16'h0) return 12'hFFF;
    an    = 4'hF;
    an[k] = 1'b0;
    return {an, SEG_TBL[nib], !(dpsep && k == 2)};
  endfunction

  // Slot-level model: every n-th cycle after reset opens the next digit slot.
  int          m_cyc  [2];
  logic [15:0] m_snap [2];
  logic [11:0] m_exp  [2];
  int          m_n;
  int          m_k;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_cyc[d]  = 0;
        m_snap[d] = 16'h0000;
        m_exp[d]  = 12'hFFF;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_n = (d == 0) ? DIV : DIV2;
        m_cyc[d]++;
        if (m_cyc[d] % m_n == 0) begin
          m_k = ((m_cyc[d] / m_n) - 1) % 4;
          if (m_k == 0) m_snap[d] = {u_if.value_hi, u_if.value_lo};
          m_exp[d] = disp(m_k, m_snap[d], u_if.blank_lz, d == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_value("model_div4", {4'h0, u_if.anode, u_if.seg, u_if.dp}, {4'h0, m_exp[0]});
      check_value("model_div7", {4'h0, u_if2.anode, u_if2.seg, u_if2.dp}, {4'h0, m_exp[1]});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_disp(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic d);
    check_value(tag, {4'h0, u_if.anode, u_if.seg, u_if.dp}, {4'h0, an, sg, d});
  endtask

  initial begin
    u_if.value_hi = 8'h12;
    u_if.value_lo = 8'h34;
    u_if.blank_lz = 1'b0;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    check_disp("reset_state", 4'b1111, 7'b1111111, 1'b1);
    wait_cyc(3);
    reset = 1'b1;

    // Reset release ordering
    wait_cyc(3);
    check_disp("dark_after_rst", 4'b1111, 7'b1111111, 1'b1);
    wait_cyc(1);
    check_disp("first_d0", 4'b1110, 7'b0011001, 1'b1);
    wait_cyc(4);
    check_disp("first_d1", 4'b1101, 7'b0110000, 1'b1);
    wait_cyc(4);
    check_disp("first_d2", 4'b1011, 7'b0100100, 1'b0);
    wait_cyc(4);
    check_disp("first_d3", 4'b0111, 7'b1111001, 1'b1);

    // Tearing: change hi during digit 1 slot
    wait_cyc(4);
    check_disp("scan2_d0", 4'b1110, 7'b0011001, 1'b1);
    wait_cyc(4);
    u_if.value_hi = 8'hAB;
    wait_cyc(4);
    check_disp("tear_d2", 4'b1011, 7'b0100100, 1'b0);
    wait_cyc(4);
    check_disp("tear_d3", 4'b0111, 7'b1111001, 1'b1);
    wait_cyc(8);
    wait_cyc(4);
    check_disp("new_d2", 4'b1011, 7'b0000011, 1'b0);
    wait_cyc(4);
    check_disp("new_d3", 4'b0111, 7'b0001000, 1'b1);

    // Leading-zero blanking
    u_if.value_hi = 8'h00;
    u_if.value_lo = 8'h05;
    u_if.blank_lz = 1'b1;
    wait_cyc(4);
    check_disp("blz_d0", 4'b1110, 7'b0010010, 1'b1);
    wait_cyc(4);
    check_disp("blz_d1", 4'b1111, 7'b1111111, 1'b1);
    wait_cyc(4);
    check_disp("blz_d2", 4'b1111, 7'b1111111, 1'b1);
    wait_cyc(4);
    check_disp("blz_d3", 4'b1111, 7'b1111111, 1'b1);
    u_if.value_lo = 8'h50;
    wait_cyc(4);
    check_disp("blz50_d0", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(4);
    check_disp("blz50_d1", 4'b1101, 7'b0010010, 1'b1);
    wait_cyc(8);

    // Hex sweep on digit 0
    u_if.blank_lz = 1'b0;
    for (int v = 0; v < 16; v++) begin
      u_if.value_lo = 8'(v);
      u_if.value_hi = 8'($urandom_range(255));
      wait_cyc(4);
      check_disp($sformatf("hex_%0h", v), 4'b1110, SEG_TBL[v], 1'b1);
      wait_cyc(12);
    end

    // Asynchronous reset during digit 2 slot
    u_if.value_hi = 8'h12;
    u_if.value_lo = 8'h34;
    wait_cyc(12);
    check_disp("pre_rst_d2", 4'b1011, 7'b0100100, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_disp("async_rst", 4'b1111, 7'b1111111, 1'b1);
    check_value("async_rst2", {4'h0, u_if2.anode, u_if2.seg, u_if2.dp}, 16'h0FFF);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(3);
    check_disp("rst2_dark", 4'b1111, 7'b1111111, 1'b1);
    wait_cyc(1);
    check_disp("rst2_d0", 4'b1110, 7'b0011001, 1'b1);

    // Randomized traffic checked by the model each cycle
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(9) == 0) u_if.value_hi = 8'($urandom_range(255));
      if ($urandom_range(9) == 0) u_if.value_lo = 8'($urandom_range(255));
      if ($urandom_range(19) == 0) u_if.value_hi = 8'h00;
      if ($urandom_range(29) == 0) u_if.blank_lz = ~u_if.blank_lz;
      wait_cyc(1);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
